meas_stream_group_capture: RTL and testbench
============================================

MEAS_STREAM_GROUP_CAPTURE -- requirements
Module: meas_stream_group_capture

Interface
REQ-001 SHALL have parameter PARM_GROUP_BYTES, default 8, giving the number of bytes per measurement group (range 1..16).
REQ-002 SHALL have parameter PARM_FIFO_DEPTH, default 4, giving the depth of the completed-group FIFO in groups (power of two, 2..16).
REQ-003 SHALL have parameter PARM_CNT_BITS, default 8, giving the width of the drop/short counters.
REQ-004 SHALL have port i_clk_20mhz, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst_20mhz, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port i_group_valid, input, 1 bit: high for the duration of one group read from the driver.
REQ-007 SHALL have port i_byte_valid, input, 1 bit: one-cycle strobe qualifying i_byte_data.
REQ-008 SHALL have port i_byte_data, input, 8 bits: streamed byte.
REQ-009 SHALL have port o_group_data, output, 8*PARM_GROUP_BYTES bits: FIFO head group.
REQ-010 SHALL have port o_group_valid, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port i_group_ready, input, 1 bit: consumer accepts the head when it is high together with o_group_valid.
REQ-012 SHALL have port o_fifo_count, output, clog2(PARM_FIFO_DEPTH)+1 bits: groups held.
REQ-013 SHALL have port o_overflow_cnt, output, PARM_CNT_BITS bits: complete groups dropped because the FIFO was full.
REQ-014 SHALL have port o_short_cnt, output, PARM_CNT_BITS bits: groups discarded as short.
REQ-015 SHALL have port o_capturing, output, 1 bit: high in any state other than ST_WAIT_GROUP.

Function
REQ-016 SHALL implement FSM states ST_WAIT_GROUP, ST_CAPTURE and ST_DONE_CYCLE.
REQ-017 ST_WAIT_GROUP SHALL clear the byte count and the shift register, and go to ST_CAPTURE on i_group_valid=1.
REQ-018 ST_CAPTURE SHALL, on i_byte_valid, shift i_byte_data into the LSB byte and increment the count; the first byte received therefore ends in the MS byte.
REQ-019 ST_CAPTURE SHALL go to ST_DONE_CYCLE the cycle after the count reaches PARM_GROUP_BYTES; further i_byte_valid strobes in ST_DONE_CYCLE SHALL be ignored.
REQ-020 ST_CAPTURE SHALL, if i_group_valid falls while the count is below PARM_GROUP_BYTES, discard the group, saturating-increment o_short_cnt, and return to ST_WAIT_GROUP.
REQ-021 ST_DONE_CYCLE SHALL wait for i_group_valid=0, then push the group into the FIFO on that transition to ST_WAIT_GROUP.
REQ-022 A pushed group SHALL appear on o_group_valid/o_group_data on the cycle after the push (FIFO is first-word-fall-through).
REQ-023 A push while the FIFO is full with no pop in the same cycle SHALL drop the new group, keep the FIFO contents, and saturating-increment o_overflow_cnt.
REQ-024 A simultaneous push and pop SHALL both take effect, including when the FIFO is full; o_fifo_count is then unchanged.
REQ-025 A pop on an empty FIFO SHALL have no effect; the FIFO pointers SHALL wrap modulo PARM_FIFO_DEPTH.
REQ-026 Counters SHALL saturate at all-ones and not wrap.

Reset
REQ-027 Assertion of reset, including mid-group, SHALL immediately force ST_WAIT_GROUP, and SHALL clear the count, the shift register, the FIFO pointers, o_fifo_count, o_overflow_cnt and o_short_cnt; o_group_valid=0, o_capturing=0 and o_group_data=0.
REQ-028 After reset deassertion, a group already in progress (i_group_valid high) SHALL NOT be captured until i_group_valid has been seen low.

Structure
REQ-029 The FSM state enum, the default group byte count and the counter width SHALL reside in the shared package pmod_stand_spi_solo_pkg.
REQ-030 The FIFO SHALL be a sub-module, group_fifo_fwft, parameterised in width and depth.

Verification
REQ-031 Reset, one group of 8 bytes 0x01..0x08 -> one output group, o_group_data=0x0102030405060708, o_group_valid high 2 cycles after i_group_valid falls.
REQ-032 Group of 5 bytes, then i_group_valid falls -> no push, o_short_cnt=1, FSM returns to ST_WAIT_GROUP.
REQ-033 i_group_ready=0, 6 complete groups at depth 4 -> o_fifo_count=4, o_overflow_cnt=2, drain yields the first 4 groups in order.
REQ-034 FIFO full, i_group_ready=1 on the push cycle -> push accepted, o_fifo_count stays 4, o_overflow_cnt unchanged.
REQ-035 10 byte strobes in one group -> captures first 8 bytes only; PARM_GROUP_BYTES=2 build: bytes 0xAB,0xCD -> 0xABCD.
REQ-036 Reset asserted after byte 3 with i_group_valid still high -> all outputs reset; no capture until i_group_valid low then high again.

Source files
------------

// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared definitions for the SPI measurement stand: capture FSM states,
// default group geometry and status counter width.
package pmod_stand_spi_solo_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_GROUP = 2'd0,
        ST_CAPTURE    = 2'd1,
        ST_DONE_CYCLE = 2'd2
    } cap_state_t;

    localparam int DEF_GROUP_BYTES = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_CNT_BITS    = 8;

    // Byte counter must reach group_bytes itself, not just group_bytes-1.
    function automatic int byte_cnt_width(input int group_bytes);
        return $clog2(group_bytes + 1);
    endfunction

endpackage

// File: rtl/group_fifo_fwft.sv
// First-word-fall-through FIFO of completed groups; head is visible while
// valid is high and is consumed by rd_en in the same cycle.
module group_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk_20mhz,
    input  logic                     i_rst_20mhz,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop, full, wr_ok;

    assign valid    = (count_reg != '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign pop      = rd_en && valid;
    // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
    assign wr_ok    = wr_en && (!full || pop);
    assign overflow = wr_en && full && !pop;
    assign count    = count_reg;
    assign rd_data  = valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(wr_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/meas_stream_group_capture.sv
// Assembles streamed bytes into fixed-size measurement groups, discards short
// groups, and queues complete groups in a FWFT FIFO for the consumer.
module meas_stream_group_capture
    import pmod_stand_spi_solo_pkg::*;
#(
    parameter int PARM_GROUP_BYTES = DEF_GROUP_BYTES,
    parameter int PARM_FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int PARM_CNT_BITS    = DEF_CNT_BITS
) (
    input  logic                              i_clk_20mhz,
    input  logic                              i_rst_20mhz,
    input  logic                              i_group_valid,
    input  logic                              i_byte_valid,
    input  logic [7:0]                        i_byte_data,
    output logic [8*PARM_GROUP_BYTES-1:0]     o_group_data,
    output logic                              o_group_valid,
    input  logic                              i_group_ready,
    output logic [$clog2(PARM_FIFO_DEPTH):0]  o_fifo_count,
    output logic [PARM_CNT_BITS-1:0]          o_overflow_cnt,
    output logic [PARM_CNT_BITS-1:0]          o_short_cnt,
    output logic                              o_capturing
);

    localparam int GROUP_W = 8 * PARM_GROUP_BYTES;
    localparam int BCNT_W  = byte_cnt_width(PARM_GROUP_BYTES);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(PARM_GROUP_BYTES);

    cap_state_t               state_reg, state_next;
    logic [BCNT_W-1:0]        byte_cnt_reg, byte_cnt_next;
    logic [GROUP_W-1:0]       shift_data_reg, shift_data_next, shifted;
    logic                     armed_reg;
    logic                     push_reg, push_next;
    logic                     short_evt, fifo_overflow;
    logic [PARM_CNT_BITS-1:0] short_cnt_reg, overflow_cnt_reg;

    generate
        if (PARM_GROUP_BYTES == 1) begin : g_shift_one
            assign shifted = i_byte_data;
        end else begin : g_shift_many
            assign shifted = {shift_data_reg[GROUP_W-9:0], i_byte_data};
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        byte_cnt_next   = byte_cnt_reg;
        shift_data_next = shift_data_reg;
        push_next       = 1'b0;
        short_evt       = 1'b0;
        case (state_reg)
            ST_WAIT_GROUP: begin
                byte_cnt_next   = '0;
                shift_data_next = '0;
                if (i_group_valid && armed_reg)
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (byte_cnt_reg == BCNT_FULL) begin
                    state_next = ST_DONE_CYCLE;
                end else if (!i_group_valid) begin
                    short_evt  = 1'b1;
                    state_next = ST_WAIT_GROUP;
                end else if (i_byte_valid) begin
                    shift_data_next = shifted;
                    byte_cnt_next   = byte_cnt_reg + BCNT_W'(1);
                end
            end
            ST_DONE_CYCLE: begin
                if (!i_group_valid) begin
                    push_next  = 1'b1;
                    state_next = ST_WAIT_GROUP;
                end
            end
            default: state_next = ST_WAIT_GROUP;
        endcase
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state_reg        <= ST_WAIT_GROUP;
            byte_cnt_reg     <= '0;
            shift_data_reg   <= '0;
            armed_reg        <= 1'b0;
            push_reg         <= 1'b0;
            short_cnt_reg    <= '0;
            overflow_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            byte_cnt_reg   <= byte_cnt_next;
            shift_data_reg <= shift_data_next;
            push_reg       <= push_next;
            // A group already running at reset release is skipped until the line idles.
            if (!i_group_valid)
                armed_reg <= 1'b1;
            if (short_evt && (short_cnt_reg != '1))
                short_cnt_reg <= short_cnt_reg + PARM_CNT_BITS'(1);
            if (fifo_overflow && (overflow_cnt_reg != '1))
                overflow_cnt_reg <= overflow_cnt_reg + PARM_CNT_BITS'(1);
        end
    end

    // The shift register is only cleared at the end of the first WAIT cycle,
    // so it still holds the finished group while push_reg is high.
    group_fifo_fwft #(
        .WIDTH (GROUP_W),
        .DEPTH (PARM_FIFO_DEPTH)
    ) u_fifo (
        .i_clk_20mhz (i_clk_20mhz),
        .i_rst_20mhz (i_rst_20mhz),
        .wr_en       (push_reg),
        .wr_data     (shift_data_reg),
        .rd_en       (i_group_ready),
        .rd_data     (o_group_data),
        .valid       (o_group_valid),
        .count       (o_fifo_count),
        .overflow    (fifo_overflow)
    );

    assign o_short_cnt    = short_cnt_reg;
    assign o_overflow_cnt = overflow_cnt_reg;
    assign o_capturing    = (state_reg != ST_WAIT_GROUP);

endmodule

// File: tb/tb_meas_stream_group_capture.sv
// Directed bench for the group capture block (8-byte build plus a 2-byte build).
module tb_meas_stream_group_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        group_valid = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        group_ready = 1'b0;
    logic [63:0] group_data;
    logic        out_valid;
    logic [2:0]  fifo_count;
    logic [7:0]  overflow_cnt;
    logic [7:0]  short_cnt;
    logic        capturing;

    logic        b_gv = 1'b0;
    logic        b_bv = 1'b0;
    logic [7:0]  b_bd = 8'h00;
    logic        b_ready = 1'b0;
    logic [15:0] b_data;
    logic        b_valid;
    logic [2:0]  b_count;
    logic [7:0]  b_ovf;
    logic [7:0]  b_short;
    logic        b_capt;

    int checks = 0;
    int failures = 0;

    always #25 clk = ~clk;

    meas_stream_group_capture dut (
        .i_clk_20mhz    (clk),
        .i_rst_20mhz    (rst),
        .i_group_valid  (group_valid),
        .i_byte_valid   (byte_valid),
        .i_byte_data    (byte_data),
        .o_group_data   (group_data),
        .o_group_valid  (out_valid),
        .i_group_ready  (group_ready),
        .o_fifo_count   (fifo_count),
        .o_overflow_cnt (overflow_cnt),
        .o_short_cnt    (short_cnt),
        .o_capturing    (capturing)
    );

    meas_stream_group_capture #(.PARM_GROUP_BYTES(2)) dut2 (
        .i_clk_20mhz    (clk),
        .i_rst_20mhz    (rst),
        .i_group_valid  (b_gv),
        .i_byte_valid   (b_bv),
        .i_byte_data    (b_bd),
        .o_group_data   (b_data),
        .o_group_valid  (b_valid),
        .i_group_ready  (b_ready),
        .o_fifo_count   (b_count),
        .o_overflow_cnt (b_ovf),
        .o_short_cnt    (b_short),
        .o_capturing    (b_capt)
    );

    function automatic logic [63:0] exp_group(input logic [7:0] base);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            v = {v[55:0], base + 8'(i)};
        return v;
    endfunction

    task automatic start_group();
        @(negedge clk);
        group_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = base + 8'(i);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    // Returns on the negedge at which the pushed group is visible.
    task automatic end_group();
        @(negedge clk);
        group_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic full_group(input logic [7:0] base);
        start_group();
        send_bytes(8, base);
        end_group();
        $display("group in: base=%02h fifo_count=%0d overflow=%0d", base, fifo_count, overflow_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (group_data !== 64'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", group_data); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
        checks++; if (short_cnt !== 8'd0) begin failures++; $display("FAIL reset_short: got %0d expected 0", short_cnt); end
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL reset_capturing: got %0b expected 0", capturing); end
        checks++; if (b_valid !== 1'b0 || b_data !== 16'h0) begin failures++; $display("FAIL reset_dut2: valid=%0b data=%h expected 0/0", b_valid, b_data); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_single_group();
        start_group();
        checks++; if (capturing !== 1'b1) begin failures++; $display("FAIL single_capturing: got %0b expected 1", capturing); end
        send_bytes(8, 8'h01);
        @(negedge clk);
        group_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early: got %0b expected 0 one cycle after fall", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b expected 1 two cycles after fall", out_valid); end
        checks++; if (group_data !== 64'h0102030405060708) begin failures++; $display("FAIL single_data: got %h expected 0102030405060708", group_data); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        $display("group out: %h", group_data);
        group_ready = 1'b1;
        @(negedge clk);
        group_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL single_pop: valid=%0b count=%0d expected 0/0", out_valid, fifo_count); end
    endtask

    task automatic test_short_group();
        start_group();
        send_bytes(5, 8'h41);
        group_valid = 1'b0;
        @(negedge clk);
        checks++; if (short_cnt !== 8'd1) begin failures++; $display("FAIL short_cnt: got %0d expected 1", short_cnt); end
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL short_state: capturing=%0b expected 0", capturing); end
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL short_nopush: valid=%0b count=%0d expected 0/0", out_valid, fifo_count); end
        $display("short group discarded: short_cnt=%0d", short_cnt);
    endtask

    task automatic test_overflow();
        for (int g = 0; g < 6; g++)
            full_group(8'h10 * 8'(g + 1));
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow_cnt !== 8'd2) begin failures++; $display("FAIL ovf_cnt: got %0d expected 2", overflow_cnt); end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (out_valid !== 1'b1 || group_data !== exp_group(8'h10 * 8'(g + 1))) begin
                failures++;
                $display("FAIL ovf_drain%0d: valid=%0b data=%h expected 1/%h", g, out_valid, group_data, exp_group(8'h10 * 8'(g + 1)));
            end
            $display("group out: %h", group_data);
            group_ready = 1'b1;
            @(negedge clk);
            group_ready = 1'b0;
        end
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL ovf_empty: valid=%0b count=%0d expected 0/0", out_valid, fifo_count); end
    endtask

    task automatic test_full_push_pop();
        for (int g = 0; g < 4; g++)
            full_group(8'h70 + 8'h10 * 8'(g));
        start_group();
        send_bytes(8, 8'hB0);
        @(negedge clk);
        group_valid = 1'b0;
        @(negedge clk);
        group_ready = 1'b1;
        @(negedge clk);
        group_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL pushpop_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow_cnt !== 8'd2) begin failures++; $display("FAIL pushpop_ovf: got %0d expected 2", overflow_cnt); end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (group_data !== exp_group(8'h80 + 8'h10 * 8'(g))) begin
                failures++;
                $display("FAIL pushpop_drain%0d: got %h expected %h", g, group_data, exp_group(8'h80 + 8'h10 * 8'(g)));
            end
            $display("group out: %h", group_data);
            group_ready = 1'b1;
            @(negedge clk);
            group_ready = 1'b0;
        end
    endtask

    task automatic test_extra_strobes();
        start_group();
        send_bytes(10, 8'hC0);
        end_group();
        checks++; if (out_valid !== 1'b1 || group_data !== exp_group(8'hC0)) begin failures++; $display("FAIL extra_data: valid=%0b data=%h expected 1/%h", out_valid, group_data, exp_group(8'hC0)); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL extra_count: got %0d expected 1", fifo_count); end
        $display("group out: %h", group_data);
        group_ready = 1'b1;
        @(negedge clk);
        group_ready = 1'b0;
    endtask

    task automatic test_two_byte_build();
        @(negedge clk);
        b_gv = 1'b1;
        @(negedge clk);
        b_bv = 1'b1; b_bd = 8'hAB;
        @(negedge clk);
        b_bd = 8'hCD;
        @(negedge clk);
        b_bv = 1'b0;
        @(negedge clk);
        b_gv = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (b_valid !== 1'b1 || b_data !== 16'hABCD) begin failures++; $display("FAIL two_byte: valid=%0b data=%h expected 1/abcd", b_valid, b_data); end
        checks++; if (b_count !== 3'd1) begin failures++; $display("FAIL two_byte_count: got %0d expected 1", b_count); end
        $display("group out (2-byte build): %h", b_data);
    endtask

    task automatic test_reset_mid_group();
        full_group(8'hD0);
        start_group();
        send_bytes(3, 8'h31);
        rst = 1'b1;
        #1;
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL midrst_capturing: got %0b expected 0", capturing); end
        checks++; if (out_valid !== 1'b0 || group_data !== 64'h0) begin failures++; $display("FAIL midrst_out: valid=%0b data=%h expected 0/0", out_valid, group_data); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow_cnt !== 8'd0 || short_cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnts: ovf=%0d short=%0d expected 0/0", overflow_cnt, short_cnt); end
        @(negedge clk);
        rst = 1'b0;
        send_bytes(8, 8'hE0);
        @(negedge clk);
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL midrst_nocapture: capturing=%0b expected 0", capturing); end
        group_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_nopush: count=%0d valid=%0b expected 0/0", fifo_count, out_valid); end
        full_group(8'hF0);
        checks++; if (out_valid !== 1'b1 || group_data !== exp_group(8'hF0)) begin failures++; $display("FAIL midrst_resume: valid=%0b data=%h expected 1/%h", out_valid, group_data, exp_group(8'hF0)); end
        $display("group out: %h", group_data);
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_short_group();
        test_overflow();
        test_full_push_pop();
        test_extra_strobes();
        test_two_byte_build();
        test_reset_mid_group();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
